vga_grid_timing_gen: RTL and testbench

Parametrised VGA timing generator for the sale terminal display. It replaces the fixed 640x480 controller timing with configurable H/V timing, pixel-clock division and sync polarity. It adds a ROWS x COLS product-tile locator that reports the current tile index and its highlight state, with tear-free shadowing of the highlight list and an optional blink mode. It sits between CLOCK_50 and the pixel colour mux that drives VGA_R/G/B.

---
 rtl/vga_grid_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_vga_grid_timing_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vga_grid_timing_gen.sv
// vga_grid_timing_gen: parametrised VGA timing with ROWS x COLS tile locator, shadowed highlight list and blink
// Ports: CLOCK_50 system clock; RESET_N sync active-low reset;
//   HighlightedProductList per-tile highlight bits (captured at frame wrap); blink_en enables blinking;
//   VGA_CLK/HS/VS/BLANK_N/SYNC_N to the DAC; pix_x/pix_y raster position;
//   tile_idx/tile_hl current tile and its gated highlight; frame_start high at pixel (0,0).
module vga_grid_timing_gen #(
  parameter int CLK_DIV      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_POL     = 0,
  parameter int COLS         = 4,
  parameter int ROWS         = 3,
  parameter int BLINK_FRAMES = 30,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int N       = ROWS * COLS,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL),
  localparam int TW      = N > 1 ? $clog2(N) : 1
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic [N-1:0]  HighlightedProductList,
  input  logic          blink_en,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [TW-1:0] tile_idx,
  output logic          tile_hl,
  output logic          frame_start
);
  localparam int DW     = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int TILE_W = H_ACTIVE / COLS;
  localparam int TILE_H = V_ACTIVE / ROWS;
  localparam int CW     = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW     = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int TXW    = TILE_W > 1 ? $clog2(TILE_W) : 1;
  localparam int TYW    = TILE_H > 1 ? $clog2(TILE_H) : 1;
  localparam int FW     = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic SYNC_ON = SYNC_POL != 0;

  logic [DW-1:0]  r_div;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [TXW-1:0] r_tcx;
  logic [TYW-1:0] r_tcy;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [N-1:0]   r_sh;
  logic [FW-1:0]  r_fc;
  logic           r_ph, r_hs, r_vs, r_blank, r_hl, r_fs, r_vclk;
  logic [TW-1:0]  r_tidx;

  logic           w_pix_en, w_x_last, w_y_last, w_line_wrap, w_frame_wrap;
  logic           w_tcx_end, w_tcy_end, w_fc_end, w_ph_nx, w_act_nx, w_hs_nx, w_vs_nx, w_hl_nx, w_fs_nx;
  logic [DW-1:0]  w_div_nx;
  logic [XW-1:0]  w_x_nx;
  logic [YW-1:0]  w_y_nx;
  logic [TXW-1:0] w_tcx_nx;
  logic [TYW-1:0] w_tcy_nx;
  logic [CW-1:0]  w_col_nx;
  logic [RW-1:0]  w_row_nx;
  logic [N-1:0]   w_sh_nx;
  logic [FW-1:0]  w_fc_nx;
  logic [TW-1:0]  w_tidx_nx;

  assign w_pix_en     = 32'(r_div) == CLK_DIV - 1;
  assign w_div_nx     = w_pix_en ? '0 : r_div + 1'b1;
  assign w_x_last     = 32'(r_x) == H_TOTAL - 1;
  assign w_y_last     = 32'(r_y) == V_TOTAL - 1;
  assign w_line_wrap  = w_pix_en & w_x_last;
  assign w_frame_wrap = w_line_wrap & w_y_last;
  assign w_x_nx       = !w_pix_en ? r_x : w_x_last ? '0 : r_x + 1'b1;
  assign w_y_nx       = !w_line_wrap ? r_y : w_y_last ? '0 : r_y + 1'b1;

  // Tile sub-counters: col/row saturate at the last tile so they stay in range through the porches.
  assign w_tcx_end = 32'(r_tcx) == TILE_W - 1;
  assign w_tcy_end = 32'(r_tcy) == TILE_H - 1;
  assign w_tcx_nx  = !w_pix_en ? r_tcx : (w_x_last || w_tcx_end) ? '0 : r_tcx + 1'b1;
  assign w_col_nx  = !w_pix_en ? r_col : w_x_last ? '0 :
                     (w_tcx_end && 32'(r_col) != COLS - 1) ? r_col + 1'b1 : r_col;
  assign w_tcy_nx  = !w_line_wrap ? r_tcy : (w_y_last || w_tcy_end) ? '0 : r_tcy + 1'b1;
  assign w_row_nx  = !w_line_wrap ? r_row : w_y_last ? '0 :
                     (w_tcy_end && 32'(r_row) != ROWS - 1) ? r_row + 1'b1 : r_row;

  // The highlight list is only sampled at frame wrap so a frame never shows a mix of two lists.
  assign w_sh_nx  = w_frame_wrap ? HighlightedProductList : r_sh;
  assign w_fc_end = 32'(r_fc) == BLINK_FRAMES - 1;
  assign w_fc_nx  = !w_frame_wrap ? r_fc : w_fc_end ? '0 : r_fc + 1'b1;
  assign w_ph_nx  = r_ph ^ (w_frame_wrap & w_fc_end);

  // Outputs are decoded from the next counter values so they change on the same edge as pix_x/pix_y.
  assign w_act_nx  = 32'(w_x_nx) < H_ACTIVE && 32'(w_y_nx) < V_ACTIVE;
  assign w_hs_nx   = 32'(w_x_nx) >= HS_BEG && 32'(w_x_nx) < HS_END;
  assign w_vs_nx   = 32'(w_y_nx) >= VS_BEG && 32'(w_y_nx) < VS_END;
  assign w_tidx_nx = w_act_nx ? TW'(32'(w_row_nx) * COLS + 32'(w_col_nx)) : '0;
  assign w_hl_nx   = w_act_nx & w_sh_nx[w_tidx_nx] & (~blink_en | w_ph_nx);
  assign w_fs_nx   = w_x_nx == '0 && w_y_nx == '0;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_div   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_tcx   <= '0;
      r_tcy   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_sh    <= '0;
      r_fc    <= '0;
      r_ph    <= 1'b0;
      r_hs    <= ~SYNC_ON;
      r_vs    <= ~SYNC_ON;
      r_blank <= 1'b0;
      r_tidx  <= '0;
      r_hl    <= 1'b0;
      r_fs    <= 1'b0;
      r_vclk  <= 1'b0;
    end else begin
      r_div   <= w_div_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_tcx   <= w_tcx_nx;
      r_tcy   <= w_tcy_nx;
      r_col   <= w_col_nx;
      r_row   <= w_row_nx;
      r_sh    <= w_sh_nx;
      r_fc    <= w_fc_nx;
      r_ph    <= w_ph_nx;
      r_hs    <= w_hs_nx ? SYNC_ON : ~SYNC_ON;
      r_vs    <= w_vs_nx ? SYNC_ON : ~SYNC_ON;
      r_blank <= w_act_nx;
      r_tidx  <= w_tidx_nx;
      r_hl    <= w_hl_nx;
      r_fs    <= w_fs_nx;
      r_vclk  <= CLK_DIV == 1 ? 1'b1 : 32'(w_div_nx) >= CLK_DIV / 2;
    end
  end

  // With CLK_DIV=1 r_vclk only acts as a run flag gating the inverted system clock.
  assign VGA_CLK     = CLK_DIV == 1 ? ~CLOCK_50 & r_vclk : r_vclk;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank;
  assign VGA_SYNC_N  = 1'b0;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign tile_idx    = r_tidx;
  assign tile_hl     = r_hl;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_grid_timing_gen.sv
// tb_vga_grid_timing_gen: randomized scoreboard bench for vga_grid_timing_gen on a reduced raster
module tb_vga_grid_timing_gen;
  localparam int CD = 3;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int SP = 0, COLS = 4, ROWS = 3, BF = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int FRC = FT * CD;
  localparam int TWID = HA / COLS;
  localparam int THGT = VA / ROWS;
  localparam int N = ROWS * COLS;

  typedef struct {
    int x, y, hs, vs, bl, sn, ti, hl, fs, vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] list;
  logic blink;
  logic vclk, hs, vs, blank_n, sync_n, hl, fs;
  logic [$clog2(HT)-1:0] px;
  logic [$clog2(VT)-1:0] py;
  logic [$clog2(N)-1:0] ti;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int k = 0;
  logic [N-1:0] m_sh = '0;

  vga_grid_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(SP),
    .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .HighlightedProductList(list), .blink_en(blink),
    .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
    .pix_x(px), .pix_y(py), .tile_idx(ti), .tile_hl(hl), .frame_start(fs)
  );

  always #5 clk = ~clk;

  // Reference model: raster position follows from the number of clocks since reset release.
  always @(posedge clk) begin
    exp_t e;
    int p, f, act;
    if (!rst_n) begin
      k = 0;
      m_sh = '0;
      e = '{x: 0, y: 0, hs: 1 - SP, vs: 1 - SP, bl: 0, sn: 0, ti: 0, hl: 0, fs: 0, vc: 0};
    end else begin
      k++;
      p = k / CD;
      f = p / FT;
      if (k % FRC == 0) m_sh = list;
      e.x = p % HT;
      e.y = (p / HT) % VT;
      act = (e.x < HA && e.y < VA) ? 1 : 0;
      e.hs = (e.x >= HA + HFP && e.x < HA + HFP + HSY) ? SP : 1 - SP;
      e.vs = (e.y >= VA + VFP && e.y < VA + VFP + VSY) ? SP : 1 - SP;
      e.bl = act;
      e.sn = 0;
      e.ti = act ? (e.y / THGT) * COLS + e.x / TWID : 0;
      e.hl = (act && m_sh[e.ti] && (!blink || ((f / BF) % 2 == 1))) ? 1 : 0;
      e.fs = (e.x == 0 && e.y == 0) ? 1 : 0;
      e.vc = ((k % CD) >= CD / 2) ? 1 : 0;
    end
    q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pix_x", int'(px), e.x);
      chk("pix_y", int'(py), e.y);
      chk("hs", int'(hs), e.hs);
      chk("vs", int'(vs), e.vs);
      chk("blank_n", int'(blank_n), e.bl);
      chk("sync_n", int'(sync_n), e.sn);
      chk("tile_idx", int'(ti), e.ti);
      chk("tile_hl", int'(hl), e.hl);
      chk("frame_start", int'(fs), e.fs);
      chk("vga_clk", int'(vclk), e.vc);
    end
  end

  task automatic run(input int n, input int pct);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < pct) list = N'($urandom);
      if ($urandom_range(0, 999) < pct) blink = 1'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    list = '0;
    blink = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    list = 12'h020;
    run(2 * FRC, 0);
    list = 12'h001;
    run(3 * FRC, 1);
    blink = 1'b1;
    list = 12'hFFF;
    run(5 * FRC, 0);
    run(FRC / 2 + int'($urandom_range(0, FRC / 4)), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(3 * FRC, 2);
    blink = 1'b0;
    run(FRC + 7, 2);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
